// File: rtl/exp_sched_pkg.sv
// Shared definitions for the exp_sched TDM sequencer.
// Default slot geometry, word widths, pipeline latencies and the FSM state type.
package exp_sched_pkg;

  localparam int unsigned NSLOT    = 8;   // operator slots per sample
  localparam int unsigned SSZ      = 3;   // slot index width, log2(NSLOT)
  localparam int unsigned WSZ      = 16;  // wave word width (log domain)
  localparam int unsigned ASZ      = 9;   // atten word width
  localparam int unsigned OSZ      = 12;  // exp_conv signed output width
  localparam int unsigned EXP_LAT  = 3;   // exp_conv latency, clocks
  localparam int unsigned RF_RDLAT = 1;   // register-file read latency, clocks

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/exp_sched_tdm_delay.sv
// Fixed-depth shift register carrying {valid, en, slot} alongside the
// register-file + exp_conv pipeline, so each result arrives tagged.
// Ports:
//   clk, reset            clock, async active-high reset (clears all stages)
//   in_valid/en/slot      tag entering the pipe this clock
//   out_valid/en/slot     tag leaving the pipe Depth clocks later
module exp_sched_tdm_delay #(
  parameter int unsigned Depth = 4,
  parameter int unsigned SlotW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_en,
  input  logic [SlotW-1:0] in_slot,
  output logic             out_valid,
  output logic             out_en,
  output logic [SlotW-1:0] out_slot
);

  localparam int unsigned TagW = SlotW + 2;

  logic [TagW-1:0] pipe_q [Depth];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= {in_valid, in_en, in_slot};
      for (int unsigned i = 1; i < Depth; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign {out_valid, out_en, out_slot} = pipe_q[Depth-1];

endmodule

// File: rtl/exp_sched.sv
// TDM sequencer sharing one exp_conv among NSlot operator slots.
// On an accepted tick it reads slots 0..NSlot-1 from the register file, one per clock,
// forwards each read to exp_conv, writes each linear result back and sums enabled slots
// into one mix sample.
// Ports:
//   clk, reset              clock, async active-high reset
//   tick, slot_en           sample strobe and per-slot mix enable (latched on accept)
//   rd_addr, rd_wave/atten  register-file read port
//   exp_wave/atten, exp_out exp_conv interface
//   res_we/addr/data        result write-back port
//   mix, mix_valid          mixed sample and its one-clock update strobe
//   busy, overrun           frame in progress; sticky tick-while-busy flag
module exp_sched
  import exp_sched_pkg::*;
#(
  parameter int unsigned NSlot  = NSLOT,
  parameter int unsigned SlotW  = SSZ,
  parameter int unsigned WaveW  = WSZ,
  parameter int unsigned AttenW = ASZ,
  parameter int unsigned OutW   = OSZ,
  parameter int unsigned RdLat  = RF_RDLAT,
  parameter int unsigned XLat   = EXP_LAT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic [NSlot-1:0]        slot_en,
  output logic [SlotW-1:0]        rd_addr,
  input  logic [WaveW-1:0]        rd_wave,
  input  logic [AttenW-1:0]       rd_atten,
  output logic [WaveW-1:0]        exp_wave,
  output logic [AttenW-1:0]       exp_atten,
  input  logic [OutW-1:0]         exp_out,
  output logic                    res_we,
  output logic [SlotW-1:0]        res_addr,
  output logic [OutW-1:0]         res_data,
  output logic [OutW+SlotW-1:0]   mix,
  output logic                    mix_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int unsigned AccW  = OutW + SlotW;
  localparam int unsigned Depth = RdLat + XLat;
  localparam logic [SlotW-1:0] LastSlot = SlotW'(NSlot - 1);

  state_e state_q, state_d;

  logic [SlotW-1:0] rd_addr_q, rd_addr_d;
  logic [NSlot-1:0] en_q, en_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic [AccW-1:0]  mix_q, mix_d;
  logic             mix_valid_q, mix_valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             res_we_q, res_we_d;
  logic [SlotW-1:0] res_addr_q, res_addr_d;
  logic [OutW-1:0]  res_data_q, res_data_d;

  logic             tail_valid, tail_en;
  logic [SlotW-1:0] tail_slot;
  logic             tick_accept;

  assign tick_accept = tick && (state_q == StIdle);

  // Register file read data goes straight to exp_conv; no local staging.
  assign exp_wave  = rd_wave;
  assign exp_atten = rd_atten;

  exp_sched_tdm_delay #(
    .Depth (Depth),
    .SlotW (SlotW)
  ) u_delay (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (state_q == StIssue),
    .in_en     (en_q[rd_addr_q]),
    .in_slot   (rd_addr_q),
    .out_valid (tail_valid),
    .out_en    (tail_en),
    .out_slot  (tail_slot)
  );

  // State register and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      en_q        <= '0;
      acc_q       <= '0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      res_we_q    <= 1'b0;
      res_addr_q  <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      en_q        <= en_d;
      acc_q       <= acc_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      res_we_q    <= res_we_d;
      res_addr_q  <= res_addr_d;
      res_data_q  <= res_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (tick) state_d = StIssue;
      StIssue: if (rd_addr_q == LastSlot) state_d = StDrain;
      // The last slot is captured on the same edge that enters StDone.
      StDrain: if (tail_valid && (tail_slot == LastSlot)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    rd_addr_d   = rd_addr_q;
    en_d        = en_q;
    acc_d       = acc_q;
    mix_d       = mix_q;
    mix_valid_d = 1'b0;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
    res_we_d    = tail_valid;
    res_addr_d  = res_addr_q;
    res_data_d  = res_data_q;

    if (tick_accept) begin
      rd_addr_d = '0;
      en_d      = slot_en;
      acc_d     = '0;
      busy_d    = 1'b1;
    end else if ((state_q == StIssue) && (rd_addr_q != LastSlot)) begin
      rd_addr_d = rd_addr_q + SlotW'(1);
    end

    // Any tick outside StIdle (including the StDone clock) is dropped and flagged.
    if (tick && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    // Write-back is unconditional; only enabled slots feed the mix.
    if (tail_valid) begin
      res_addr_d = tail_slot;
      res_data_d = exp_out;
      if (tail_en) begin
        acc_d = acc_q + {{SlotW{exp_out[OutW-1]}}, exp_out};
      end
    end

    if (state_q == StDone) begin
      mix_d       = acc_q;
      mix_valid_d = 1'b1;
      busy_d      = 1'b0;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign res_we    = res_we_q;
  assign res_addr  = res_addr_q;
  assign res_data  = res_data_q;
  assign mix       = mix_q;
  assign mix_valid = mix_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule
